// File: rtl/dcache_access_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_access_ctrl
// N-way set-associative, write-back data cache controller. It holds the tag,
// valid, dirty, age (LRU) and data arrays. Hits resolve combinationally in
// the request cycle. A miss writes back a dirty victim (WB), then refills the
// block from memory (FETCH). A halt flushes every dirty line (FLUSH) and the
// controller then parks in DONE.
//
// Ports
//   CLK, RST             clock, synchronous active-high reset
//   dmemREN/dmemWEN      CPU read / write request (write wins)
//   dmemaddr/dmemstore   CPU byte address / write data
//   halt                 start flush (level)
//   dhit/dmemload        request serviced this cycle / read data
//   dREN/dWEN            memory read / write strobe
//   daddr/dstore         memory word address / write data
//   dwait/dload          memory busy / memory read data
//   flushed              flush complete, sticky until reset
// -----------------------------------------------------------------------------
module dcache_access_ctrl #(
  parameter int WAYS  = 2,
  parameter int SETS  = 8,
  parameter int WORDS = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic        dwait,
  input  logic [31:0] dload,
  output logic        flushed
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam int CNT_W = (OFF_W > 0) ? OFF_W : 1;
  localparam int IX_W  = (IDX_W > 0) ? IDX_W : 1;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {IDLE, WB, FETCH, FLUSH, DONE} state_t;

  // Cache arrays
  logic [31:0]      r_data  [SETS][WAYS][WORDS];
  logic [TAG_W-1:0] r_tag   [SETS][WAYS];
  logic             r_valid [SETS][WAYS];
  logic             r_dirty [SETS][WAYS];
  logic [WAY_W-1:0] r_age   [SETS][WAYS];

  // Control state
  state_t           r_state, w_state_n;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  logic [WAY_W-1:0] r_victim, w_victim_n;
  logic [IX_W-1:0]  r_fl_set, w_fl_set_n;
  logic [WAY_W-1:0] r_fl_way, w_fl_way_n;

  // Request decode
  logic [TAG_W-1:0] w_tag;
  logic [IX_W-1:0]  w_idx;
  logic [CNT_W-1:0] w_word;
  logic             w_req, w_xfer, w_last, w_fl_last;

  assign w_tag     = dmemaddr[31 -: TAG_W];
  assign w_idx     = IX_W'((dmemaddr >> (2 + OFF_W)) & 32'(SETS - 1));
  assign w_word    = CNT_W'((dmemaddr >> 2) & 32'(WORDS - 1));
  assign w_req     = dmemREN | dmemWEN;
  assign w_xfer    = ~dwait;
  assign w_last    = (r_cnt == CNT_W'(WORDS - 1));
  assign w_fl_last = (r_fl_set == IX_W'(SETS - 1)) && (r_fl_way == WAY_W'(WAYS - 1));

  function automatic logic [31:0] mk_addr(input logic [TAG_W-1:0] tag,
                                          input logic [IX_W-1:0]  idx,
                                          input logic [CNT_W-1:0] word);
    return (32'(tag) << (2 + OFF_W + IDX_W)) | (32'(idx) << (2 + OFF_W)) | (32'(word) << 2);
  endfunction

  // Hit detection and victim choice for the addressed set
  logic             w_hit, w_found;
  logic [WAY_W-1:0] w_hit_way, w_vict;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can leave it unassigned and infer a latch.
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_found   = 1'b0;
    w_vict    = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (!w_hit && r_valid[w_idx][i] && (r_tag[w_idx][i] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(i);
      end
    end
    // Lowest invalid way first; otherwise the oldest way.
    for (int i = 0; i < WAYS; i++) begin
      if (!w_found && !r_valid[w_idx][i]) begin
        w_found = 1'b1;
        w_vict  = WAY_W'(i);
      end
    end
    for (int i = 0; i < WAYS; i++) begin
      if (!w_found && (r_age[w_idx][i] == WAY_W'(WAYS - 1))) w_vict = WAY_W'(i);
    end
  end

  // Array update strobes
  logic             w_touch, w_wr_hit, w_wb_done, w_fill_word, w_fill_done;
  logic             w_fl_wb_done, w_fl_clear;
  logic [WAY_W-1:0] w_touch_way;

  // Next-state and output logic
  always_comb begin
    w_state_n    = r_state;
    w_cnt_n      = r_cnt;
    w_victim_n   = r_victim;
    w_fl_set_n   = r_fl_set;
    w_fl_way_n   = r_fl_way;
    dhit         = 1'b0;
    dmemload     = '0;
    dREN         = 1'b0;
    dWEN         = 1'b0;
    daddr        = '0;
    dstore       = '0;
    flushed      = 1'b0;
    w_touch      = 1'b0;
    w_touch_way  = w_hit_way;
    w_wr_hit     = 1'b0;
    w_wb_done    = 1'b0;
    w_fill_word  = 1'b0;
    w_fill_done  = 1'b0;
    w_fl_wb_done = 1'b0;
    w_fl_clear   = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (halt) begin
          w_state_n  = FLUSH;
          w_cnt_n    = '0;
          w_fl_set_n = '0;
          w_fl_way_n = '0;
        end else if (w_req) begin
          if (w_hit) begin
            dhit     = 1'b1;
            dmemload = r_data[w_idx][w_hit_way][w_word];
            w_touch  = 1'b1;
            w_wr_hit = dmemWEN;
          end else begin
            w_victim_n = w_vict;
            w_cnt_n    = '0;
            w_state_n  = (r_valid[w_idx][w_vict] && r_dirty[w_idx][w_vict]) ? WB : FETCH;
          end
        end
      end

      WB: begin
        dWEN   = 1'b1;
        daddr  = mk_addr(r_tag[w_idx][r_victim], w_idx, r_cnt);
        dstore = r_data[w_idx][r_victim][r_cnt];
        if (w_xfer) begin
          if (w_last) begin
            w_cnt_n   = '0;
            w_wb_done = 1'b1;
            w_state_n = FETCH;
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end
      end

      FETCH: begin
        dREN  = 1'b1;
        daddr = mk_addr(w_tag, w_idx, r_cnt);
        if (w_xfer) begin
          w_fill_word = 1'b1;
          if (w_last) begin
            w_cnt_n     = '0;
            w_fill_done = 1'b1;
            w_touch     = 1'b1;
            w_touch_way = r_victim;
            w_state_n   = IDLE;
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end
      end

      FLUSH: begin
        // A dirty pair is written back first; the pair is then revisited
        // clean on the following cycle, invalidated and the scan advances.
        if (r_dirty[r_fl_set][r_fl_way]) begin
          dWEN   = 1'b1;
          daddr  = mk_addr(r_tag[r_fl_set][r_fl_way], r_fl_set, r_cnt);
          dstore = r_data[r_fl_set][r_fl_way][r_cnt];
          if (w_xfer) begin
            if (w_last) begin
              w_cnt_n      = '0;
              w_fl_wb_done = 1'b1;
            end else begin
              w_cnt_n = r_cnt + 1'b1;
            end
          end
        end else begin
          w_fl_clear = 1'b1;
          if (w_fl_last) begin
            w_state_n = DONE;
          end else if (r_fl_way == WAY_W'(WAYS - 1)) begin
            w_fl_way_n = '0;
            w_fl_set_n = r_fl_set + 1'b1;
          end else begin
            w_fl_way_n = r_fl_way + 1'b1;
          end
        end
      end

      DONE: flushed = 1'b1;

      default: w_state_n = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (RST) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_victim <= '0;
      r_fl_set <= '0;
      r_fl_way <= '0;
    end else begin
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_victim <= w_victim_n;
      r_fl_set <= w_fl_set_n;
      r_fl_way <= w_fl_way_n;
    end
  end

  // Line status: valid, dirty and age
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
          r_dirty[s][w] <= 1'b0;
          r_age[s][w]   <= WAY_W'(w);
        end
      end
    end else begin
      // Touched way becomes youngest; ways younger than its old age shift up.
      if (w_touch) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == w_touch_way) r_age[w_idx][w] <= '0;
          else if (r_age[w_idx][w] < r_age[w_idx][w_touch_way])
            r_age[w_idx][w] <= r_age[w_idx][w] + 1'b1;
        end
      end
      if (w_wr_hit)  r_dirty[w_idx][w_hit_way] <= 1'b1;
      if (w_wb_done) r_dirty[w_idx][r_victim]  <= 1'b0;
      if (w_fill_done) begin
        r_valid[w_idx][r_victim] <= 1'b1;
        r_dirty[w_idx][r_victim] <= 1'b0;
      end
      if (w_fl_wb_done) r_dirty[r_fl_set][r_fl_way] <= 1'b0;
      if (w_fl_clear) begin
        r_valid[r_fl_set][r_fl_way] <= 1'b0;
        r_dirty[r_fl_set][r_fl_way] <= 1'b0;
      end
    end
  end

  // Tag and data storage
  // NOTE: the tag and data arrays have no reset; contents are qualified by valid, so they map onto plain RAM.
  always_ff @(posedge CLK) begin
    if (w_wr_hit)    r_data[w_idx][w_hit_way][w_word] <= dmemstore;
    if (w_fill_word) r_data[w_idx][r_victim][r_cnt]   <= dload;
    if (w_fill_done) r_tag[w_idx][r_victim]           <= w_tag;
  end

endmodule

// File: doc/dcache_access_ctrl.md
# dcache_access_ctrl

Parametrised N-way set-associative data-cache controller, the successor to the fixed 2-way, 2-word access logic. It holds the tag, valid, dirty and LRU state and the data storage. It resolves hits in the same cycle and runs a miss state machine that writes back the dirty victim and then refills the block from memory. On halt it flushes every dirty line to memory. It sits between the pipeline memory stage and the memory arbiter.

## Interface
Parameters:
- WAYS, 2: associativity; power of two, 1–8.
- SETS, 8: number of sets; power of two.
- WORDS, 2: 32-bit words per block; power of two.

Address split:
- [1:0] byte offset, ignored.
- Then the word offset, log2(WORDS) bits.
- Then the index, log2(SETS) bits.
- Tag is the remaining upper bits.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- dmemREN  in  1  CPU read request.
- dmemWEN  in  1  CPU write request; has priority if both requests are high.
- dmemaddr  in  32  CPU byte address.
- dmemstore  in  32  CPU write data.
- halt  in  1  start flush; level-sensitive.
- dhit  out  1  request serviced this cycle.
- dmemload  out  32  read data; valid when dhit=1.
- dREN  out  1  memory read.
- dWEN  out  1  memory write.
- daddr  out  32  memory word address, low two bits always 0.
- dstore  out  32  memory write data.
- dwait  in  1  memory busy; a word transfer completes in the cycle dREN or dWEN is high and dwait=0.
- dload  in  32  memory read data; sampled when the transfer completes.
- flushed  out  1  flush complete; stays high until reset.

## Operation
- States: IDLE, WB, FETCH, FLUSH, DONE.
- **Lookup in IDLE:** a hit is a valid way whose tag matches. Hit detection is combinational.
  - Read hit: dhit=1 and dmemload = the addressed word.
  - Write hit: the word is written, dirty is set and dhit=1, all in that cycle.
- **LRU update:** each set holds an age of log2(WAYS) bits per way. On a hit or fill, the touched way's age becomes 0. Every way whose age was below the touched way's old age increments.
- **Victim selection:** the lowest-index invalid way. If all ways are valid, the way with age WAYS-1.
- **Miss handling:** a miss with a dirty victim goes to WB; a miss with a clean victim goes to FETCH.
- **WB:** word counter runs 0..WORDS-1. Each word drives dWEN=1, daddr = {victim tag, index, counter, 2'b00} and dstore = the victim word. After the last word the victim's dirty bit is cleared and the state moves to FETCH.
- **FETCH:** word counter runs 0..WORDS-1. Each word drives dREN=1 and daddr = {request tag, index, counter, 2'b00}, and dload is written into the victim way. After the last word: tag written, valid=1, dirty=0, state returns to IDLE. The request then hits on the next cycle; for a write, the write is applied on that hit.
- **FLUSH entry:** halt=1 in IDLE enters FLUSH. A halt raised during WB or FETCH is honoured only after the state returns to IDLE.
- **FLUSH scan:** goes through (set, way) pairs in order: set 0 ways 0..WAYS-1, then set 1, and so on. Dirty lines are written back word by word, same as WB. Every line's valid and dirty are cleared. After the last pair the state moves to DONE.
- **DONE:** flushed=1, dhit=0, no memory traffic, and all CPU requests are ignored.
- **Reset values:** all outputs 0; every valid and dirty bit 0; ages = way index; counters 0; state IDLE. Data contents are don't-care.
- **Reset mid-operation:** reset wins in any state. A partial transfer is abandoned; memory may hold partially written words.
- No request (both dmemREN and dmemWEN low): dhit=0, no memory traffic, no state change.

## Timing
- Hit latency: 0 cycles; dhit is combinational in the request cycle.
- Clean-victim miss: dhit asserts WORDS×(1+wait) + 1 cycles after the request, where wait is the number of dwait-high cycles per word.
- Dirty-victim miss: 2×WORDS×(1+wait) + 1 cycles.
- daddr, dstore, dREN and dWEN are held stable while dwait=1. The word counter advances only when a transfer completes.
- The memory interface never asserts dREN and dWEN in the same cycle.
- Flush of D dirty lines takes SETS×WAYS + D×WORDS×(1+wait) cycles plus 1 cycle to enter DONE.

## Test plan
Defaults WAYS=2, SETS=8, WORDS=2, dwait=0 unless stated; index = addr[5:3], tag = addr[31:6].
- **Cold read:** after reset, read 0x40 with memory[0x40]=0x1111_1111. Expected: dREN to daddr 0x40 then 0x44, then dhit=1 with dmemload=0x1111_1111 three cycles after the request.
- **Dirty eviction:**
  - Write 0x40 with data 0xDEAD_BEEF, then read 0x80.
  - Then read 0xC0. Expected: dWEN to 0x40 with dstore 0xDEAD_BEEF, dWEN to 0x44, then dREN to 0xC0 and 0xC4.
- **LRU:** read 0x40, then 0x80, then 0x40, then 0xC0. Expected: the 0x80 line is replaced with no dWEN; a following read of 0x40 hits in 0 cycles.
- **Stretched memory:** dwait high 3 cycles per word on a cold read. Expected: daddr and dREN stable through the stall, dhit=1 exactly 9 cycles after the request.
- **Halt flush:** dirty lines 0x40 and 0x108, then halt=1. Expected: exactly 4 dWEN transfers in the order 0x40, 0x44, 0x108, 0x10C; then flushed=1; a subsequent dmemREN gives dhit=0.
- **Reset mid-FETCH:** assert RST during the second FETCH word. Expected: all outputs 0 the next cycle; re-reading 0x40 misses and refetches both words.
